// File: rtl/ct_f_spsram_512x52_ctrl_pkg.sv
// Shared encodings for the 512x52 SRAM access controller.
package ct_f_spsram_512x52_ctrl_pkg;

  typedef enum logic {StInit, StRun} state_e;

  localparam int unsigned HalfWidth = 26;

  // Macro enables are active-low; these are their deasserted levels.
  localparam logic CenIdle  = 1'b1;
  localparam logic GwenIdle = 1'b1;
  localparam logic WenIdle  = 1'b1;

endpackage

// File: rtl/ct_f_rr_arb2.sv
// Two-way round-robin arbiter; the favoured requester flips after every grant.
module ct_f_rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       ack,
  output logic [1:0] grant
);

  // High when requester 1 wins a tie.
  logic prio_q;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !prio_q)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q <= 1'b0;
    end else if (ack && (grant != 2'b00)) begin
      prio_q <= grant[0];
    end
  end

endmodule

// File: rtl/ct_f_spsram_512x52_ctrl.sv
// Clears the SRAM after reset, then arbitrates two clients onto the single macro port.
module ct_f_spsram_512x52_ctrl
  import ct_f_spsram_512x52_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter int unsigned           DEPTH      = 512,
  parameter int unsigned           DATA_WIDTH = 52,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  init_done,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [1:0]            req0_hwe,
  output logic                  req0_rdy,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [1:0]            req1_hwe,
  output logic                  req1_rdy,
  output logic                  rsp0_vld,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  rtag_vld_q, rtag_vld_d;
  logic                  rtag_id_q, rtag_id_d;

  logic                  run;
  logic [1:0]            req, grant;
  logic                  ack, sel;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]            sel_hwe;

  assign run = (state_q == StRun);
  assign req = {req1_vld, req0_vld} & {2{run}};

  ct_f_rr_arb2 u_arb (
    .CLK   (CLK),
    .RST   (RST),
    .req   (req),
    .ack   (ack),
    .grant (grant)
  );

  assign ack       = |grant;
  assign sel       = grant[1];
  assign req0_rdy  = grant[0];
  assign req1_rdy  = grant[1];
  assign init_done = run;

  assign sel_wr    = sel ? req1_wr    : req0_wr;
  assign sel_addr  = sel ? req1_addr  : req0_addr;
  assign sel_wdata = sel ? req1_wdata : req0_wdata;
  assign sel_hwe   = sel ? req1_hwe   : req0_hwe;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rtag_vld_d = 1'b0;
    rtag_id_d  = rtag_id_q;
    sram_cen   = CenIdle;
    sram_gwen  = GwenIdle;
    sram_wen   = {DATA_WIDTH{WenIdle}};
    sram_a     = a_q;
    sram_d     = d_q;
    unique case (state_q)
      StInit: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt_q;
        sram_d    = INIT_VALUE;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (ack) begin
          sram_cen = 1'b0;
          sram_a   = sel_addr;
          if (sel_wr) begin
            sram_gwen = 1'b0;
            sram_d    = sel_wdata;
            sram_wen  = {{(DATA_WIDTH - HalfWidth){~sel_hwe[1]}}, {HalfWidth{~sel_hwe[0]}}};
          end else begin
            rtag_vld_d = 1'b1;
            rtag_id_d  = sel;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      a_q        <= '0;
      d_q        <= INIT_VALUE;
      rtag_vld_q <= 1'b0;
      rtag_id_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= sram_a;
      d_q        <= sram_d;
      rtag_vld_q <= rtag_vld_d;
      rtag_id_q  <= rtag_id_d;
    end
  end

  // A response still in flight when reset arrives is suppressed immediately.
  assign rsp0_vld   = rtag_vld_q && !rtag_id_q && !RST;
  assign rsp1_vld   = rtag_vld_q &&  rtag_id_q && !RST;
  assign rsp0_rdata = rsp0_vld ? sram_q : '0;
  assign rsp1_rdata = rsp1_vld ? sram_q : '0;

endmodule
